// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: muxes UART commands to the motion consumer,
// or, during a tour, turns each one-hot solver move into a vertical and a horizontal leg.
module tour_cmd #(
    parameter int LAST_INDX = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [4:0] LAST = 5'(LAST_INDX);
    localparam logic [3:0] OP_VERT = 4'h2;
    localparam logic [3:0] OP_HORZ = 4'h3;
    localparam logic [7:0] HD_NORTH = 8'h00;
    localparam logic [7:0] HD_SOUTH = 8'hFF;
    localparam logic [7:0] HD_EAST  = 8'h3F;
    localparam logic [7:0] HD_WEST  = 8'h7F;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    state_t     r_state;
    state_t     w_nxt_state;
    logic [4:0] r_mv_indx;
    logic [4:0] w_nxt_indx;

    logic [7:0] w_v_head;
    logic [3:0] w_v_cnt;
    logic [7:0] w_h_head;
    logic [3:0] w_h_cnt;
    logic       w_last;

    // Move bit -> (dx,dy); illegal (non-one-hot) moves become zero-length legs.
    always_comb begin
        w_v_head = HD_NORTH;
        w_v_cnt  = 4'd0;
        w_h_head = HD_NORTH;
        w_h_cnt  = 4'd0;
        case (move)
            8'h01: begin w_v_head = HD_NORTH; w_v_cnt = 4'd2; w_h_head = HD_WEST; w_h_cnt = 4'd1; end
            8'h02: begin w_v_head = HD_NORTH; w_v_cnt = 4'd2; w_h_head = HD_EAST; w_h_cnt = 4'd1; end
            8'h04: begin w_v_head = HD_NORTH; w_v_cnt = 4'd1; w_h_head = HD_WEST; w_h_cnt = 4'd2; end
            8'h08: begin w_v_head = HD_SOUTH; w_v_cnt = 4'd1; w_h_head = HD_WEST; w_h_cnt = 4'd2; end
            8'h10: begin w_v_head = HD_SOUTH; w_v_cnt = 4'd2; w_h_head = HD_WEST; w_h_cnt = 4'd1; end
            8'h20: begin w_v_head = HD_SOUTH; w_v_cnt = 4'd2; w_h_head = HD_EAST; w_h_cnt = 4'd1; end
            8'h40: begin w_v_head = HD_SOUTH; w_v_cnt = 4'd1; w_h_head = HD_EAST; w_h_cnt = 4'd2; end
            8'h80: begin w_v_head = HD_NORTH; w_v_cnt = 4'd1; w_h_head = HD_EAST; w_h_cnt = 4'd2; end
            default: ;
        endcase
    end

    assign w_last = (r_mv_indx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_mv_indx <= w_nxt_indx;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_indx  = r_mv_indx;
        cmd         = cmd_UART;
        cmd_rdy     = cmd_rdy_UART;
        resp        = RESP_BUSY;
        case (r_state)
            IDLE: begin
                resp = RESP_DONE;
                if (start_tour) begin
                    w_nxt_indx  = '0;
                    w_nxt_state = VERT;
                end
            end
            VERT: begin
                cmd     = {OP_VERT, w_v_head, w_v_cnt};
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) w_nxt_state = HOLD_V;
            end
            HOLD_V: begin
                cmd     = {OP_VERT, w_v_head, w_v_cnt};
                cmd_rdy = 1'b0;
                if (send_resp) w_nxt_state = HORZ;
            end
            HORZ: begin
                cmd     = {OP_HORZ, w_h_head, w_h_cnt};
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) w_nxt_state = HOLD_H;
            end
            HOLD_H: begin
                cmd     = {OP_HORZ, w_h_head, w_h_cnt};
                cmd_rdy = 1'b0;
                if (w_last) resp = RESP_DONE;
                if (send_resp) begin
                    if (w_last) begin
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_indx  = r_mv_indx + 5'd1;
                        w_nxt_state = VERT;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign mv_indx = r_mv_indx;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: vector table, deterministic tour sequences,
// and randomized tours checked against a transaction-level command list.
module tb_tour_cmd;

    localparam int LAST = 23;
    localparam int NCMD = 2 * (LAST + 1);

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    logic [7:0] sol [32];
    int checks = 0;
    int errors = 0;

    tour_cmd #(.LAST_INDX(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .resp(resp)
    );

    // Solver model: presents the stored move for whatever index is being read.
    assign move = sol[mv_indx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: knight offsets as plain integers, legs derived from signs/magnitudes.
    function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit vert);
        int dxs [8];
        int dys [8];
        int dx;
        int dy;
        int mag;
        logic [7:0] head;
        dxs = '{-1, 1, -2, -2, -1, 1, 2, 2};
        dys = '{2, 2, 1, -1, -2, -2, -1, 1};
        dx = 0;
        dy = 0;
        if ($countones(mv) == 1)
            for (int b = 0; b < 8; b++) if (mv[b]) begin dx = dxs[b]; dy = dys[b]; end
        if (vert) begin
            mag  = (dy < 0) ? -dy : dy;
            head = (dy < 0) ? 8'hFF : 8'h00;
            return {4'h2, head, 4'(mag)};
        end
        mag  = (dx < 0) ? -dx : dx;
        head = (dx > 0) ? 8'h3F : ((dx < 0) ? 8'h7F : 8'h00);
        return {4'h3, head, 4'(mag)};
    endfunction

    task automatic chk_idle(input string nm);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom);
        #1;
        chk({nm, "_cmd"}, cmd, cmd_UART);
        chk({nm, "_rdy"}, cmd_rdy, cmd_rdy_UART);
        chk({nm, "_resp"}, resp, 8'hA5);
    endtask

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] v;
        logic [15:0] h;
    } vec_t;
    vec_t vec [11];

    // Consumer: clr one cycle after cmd_rdy, send_resp five cycles after clr.
    // Optionally re-pulses start_tour in HOLD_V of move 7, or resets in HORZ of move rst_at.
    task automatic tour_det(input int rst_at, input bit restart_pulse);
        int ncmd;
        ncmd = 0;
        cmd_UART = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        start_tour = 1'b1; tick(); start_tour = 1'b0;
        for (int k = 0; k < NCMD; k++) begin
            chk("det_rdy", cmd_rdy, 1);
            chk("det_cmd", cmd, exp_cmd(sol[k / 2], (k % 2) == 0));
            chk("det_idx", mv_indx, k / 2);
            if (cmd_rdy) ncmd++;
            if (rst_at >= 0 && k == 2 * rst_at + 1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_idx", mv_indx, 0);
                chk_idle("rst_mid");
                rst_n = 1'b1;
                repeat (3) tick();
                chk_idle("rst_after");
                chk("rst_after_idx", mv_indx, 0);
                return;
            end
            tick();
            clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
            chk("det_hold_rdy", cmd_rdy, 0);
            chk("det_hold_resp", resp, (k == NCMD - 1) ? 8'hA5 : 8'h5A);
            if (restart_pulse && k == 14) begin
                start_tour = 1'b1; tick(); start_tour = 1'b0;
                chk("restart_idx", mv_indx, 7);
                chk("restart_rdy", cmd_rdy, 0);
                repeat (3) tick();
            end else begin
                repeat (4) tick();
            end
            send_resp = 1'b1; tick(); send_resp = 1'b0;
        end
        chk("det_ncmd", ncmd, NCMD);
        chk("det_end_idx", mv_indx, LAST);
        chk_idle("det_end");
    endtask

    task automatic rand_tour();
        logic [15:0] exp_q [$];
        int  k;
        int  cyc;
        bit  acc;
        k = 0;
        cyc = 0;
        acc = 1'b0;
        for (int i = 0; i <= LAST; i++) begin
            sol[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            exp_q.push_back(exp_cmd(sol[i], 1'b1));
            exp_q.push_back(exp_cmd(sol[i], 1'b0));
        end
        start_tour = 1'b1; tick(); start_tour = 1'b0;
        while (k < exp_q.size() && cyc < 5000) begin
            chk("rnd_rdy", cmd_rdy, !acc);
            chk("rnd_cmd", cmd, exp_q[k]);
            chk("rnd_idx", mv_indx, k / 2);
            chk("rnd_resp", resp, (acc && k == exp_q.size() - 1) ? 8'hA5 : 8'h5A);
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            start_tour   = ($urandom_range(0, 7) == 0);
            if (!acc) begin
                clr_cmd_rdy = ($urandom_range(0, 2) == 0);
                send_resp   = ($urandom_range(0, 3) == 0);
                acc         = clr_cmd_rdy;
            end else begin
                clr_cmd_rdy = ($urandom_range(0, 3) == 0);
                send_resp   = ($urandom_range(0, 3) == 0);
                if (send_resp) begin
                    k++;
                    acc = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        start_tour  = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        chk("rnd_done", k, exp_q.size());
        chk("rnd_end_idx", mv_indx, LAST);
        chk_idle("rnd_end");
    endtask

    initial begin
        vec[0]  = '{8'h01, 16'h2002, 16'h37F1};
        vec[1]  = '{8'h02, 16'h2002, 16'h33F1};
        vec[2]  = '{8'h04, 16'h2001, 16'h37F2};
        vec[3]  = '{8'h08, 16'h2FF1, 16'h37F2};
        vec[4]  = '{8'h10, 16'h2FF2, 16'h37F1};
        vec[5]  = '{8'h20, 16'h2FF2, 16'h33F1};
        vec[6]  = '{8'h40, 16'h2FF1, 16'h33F2};
        vec[7]  = '{8'h80, 16'h2001, 16'h33F2};
        vec[8]  = '{8'h00, 16'h2000, 16'h3000};
        vec[9]  = '{8'h03, 16'h2000, 16'h3000};
        vec[10] = '{8'hFF, 16'h2000, 16'h3000};
        for (int i = 0; i < 32; i++) sol[i] = 8'h01;

        rst_n = 1'b0;
        start_tour = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1;
        #3;
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_rdy", cmd_rdy, 1);
        chk("rst_idx", mv_indx, 0);
        chk("rst_resp", resp, 8'hA5);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("idle");

        for (int i = 0; i < 11; i++) begin
            sol[0] = vec[i].mv;
            cmd_rdy_UART = 1'b1;
            start_tour = 1'b1; tick(); start_tour = 1'b0;
            chk("tbl_v_cmd", cmd, vec[i].v);
            chk("tbl_v_rdy", cmd_rdy, 1);
            chk("tbl_v_resp", resp, 8'h5A);
            clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
            chk("tbl_hv_rdy", cmd_rdy, 0);
            chk("tbl_hv_cmd", cmd, vec[i].v);
            send_resp = 1'b1; tick(); send_resp = 1'b0;
            chk("tbl_h_cmd", cmd, vec[i].h);
            chk("tbl_h_rdy", cmd_rdy, 1);
            rst_n = 1'b0;
            #1;
            chk("tbl_rst_idx", mv_indx, 0);
            chk_idle("tbl_rst");
            rst_n = 1'b1;
            tick();
        end

        for (int i = 0; i <= LAST; i++) sol[i] = 8'(1 << $urandom_range(0, 7));
        tour_det(-1, 1'b1);
        tick();
        tour_det(10, 1'b0);
        tick();
        rand_tour();
        tick();
        rand_tour();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have parameter LAST_INDX, default 23, index of final tour move.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_tour  input  1  one-cycle pulse marking tour solution ready.
REQ-005 SHALL have port move  input  8  one-hot knight move addressed by mv_indx.
REQ-006 SHALL have port mv_indx  output  5  index of move being read from the solver.
REQ-007 SHALL have port cmd_UART  input  16  command from UART path.
REQ-008 SHALL have port cmd_rdy_UART  input  1  UART command valid.
REQ-009 SHALL have port clr_cmd_rdy  input  1  consumer has accepted current cmd.
REQ-010 SHALL have port send_resp  input  1  consumer finished executing a command.
REQ-011 SHALL have port cmd  output  16  muxed command to motion consumer.
REQ-012 SHALL have port cmd_rdy  output  1  cmd valid.
REQ-013 SHALL have port resp  output  8  response byte for the UART path.

Function
REQ-014 SHALL implement states IDLE, VERT, HOLD_V, HORZ, HOLD_H.
REQ-015 In IDLE, cmd SHALL equal cmd_UART and cmd_rdy SHALL equal cmd_rdy_UART (combinational pass-through).
REQ-016 In any other state, cmd SHALL be the generated tour command and cmd_rdy SHALL be 1 only in VERT and HORZ.
REQ-017 Command format SHALL be cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] square count.
REQ-018 Vertical leg SHALL use opcode 4'h2, heading 8'h00 if dy>0 else 8'hFF, count |dy|.
REQ-019 Horizontal leg SHALL use opcode 4'h3, heading 8'h3F if dx>0 else 8'h7F, count |dx|.
REQ-020 Move decode (bit: dx,dy) SHALL be: 0:-1,+2; 1:+1,+2; 2:-2,+1; 3:-2,-1; 4:-1,-2; 5:+1,-2; 6:+2,-1; 7:+2,+1.
REQ-021 Non-one-hot move SHALL decode to heading 8'h00, count 0, same opcodes.
REQ-022 IDLE with start_tour=1 SHALL clear mv_indx to 0 and go to VERT next cycle.
REQ-023 VERT with clr_cmd_rdy=1 SHALL go to HOLD_V; otherwise hold.
REQ-024 HOLD_V with send_resp=1 SHALL go to HORZ; otherwise hold.
REQ-025 HORZ with clr_cmd_rdy=1 SHALL go to HOLD_H; otherwise hold.
REQ-026 HOLD_H with send_resp=1 SHALL go to IDLE if mv_indx==LAST_INDX, else increment mv_indx by 1 and go to VERT.
REQ-027 mv_indx SHALL change only on REQ-022 and REQ-026; it SHALL never wrap past LAST_INDX.
REQ-028 start_tour outside IDLE SHALL be ignored.
REQ-029 clr_cmd_rdy in HOLD_V/HOLD_H and send_resp in VERT/HORZ SHALL be ignored.
REQ-030 resp SHALL be 8'hA5 when state is IDLE or (HOLD_H and mv_indx==LAST_INDX), else 8'h5A; combinational.
REQ-031 move SHALL be sampled combinationally each cycle; solver holds move stable while mv_indx is stable.

Reset
REQ-032 On rst_n low, state SHALL be IDLE and mv_indx 0 immediately, regardless of clk.
REQ-033 After reset, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
REQ-034 Reset asserted mid-tour SHALL abandon the tour; no tour command is issued until next start_tour.

Verification
REQ-035 Reset, cmd_UART=16'h1234, cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, mv_indx=0, resp=8'hA5.
REQ-036 start_tour pulse, move=8'h01 -> next cycle cmd=16'h2002, cmd_rdy=1; after clr_cmd_rdy cmd_rdy=0; after send_resp cmd=16'h37F1, cmd_rdy=1.
REQ-037 move=8'h40 -> vertical cmd=16'h2FF1, horizontal cmd=16'h33F2.
REQ-038 Full 24-move tour with consumer model (clr_cmd_rdy 1 cycle after cmd_rdy, send_resp 5 cycles later) -> exactly 48 commands, mv_indx 0..23 in order, return to IDLE, resp=8'h5A mid-tour, 8'hA5 at end.
REQ-039 start_tour re-pulsed in HOLD_V at mv_indx=7 -> ignored, mv_indx stays 7, sequence continues.
REQ-040 rst_n low in HORZ at mv_indx=10 -> immediately IDLE, mv_indx=0, cmd follows cmd_UART.
